// File: rtl/proc_mem_responder.sv
// Memory-side responder for the 16-bit pipelined processor: holds IM/DM, preloads them
// from a host port, pulses start, serves fetches and data accesses, then self-checks one DM word.
module proc_mem_responder #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int IM_DEPTH       = 256,
  parameter int DM_DEPTH       = 256,
  parameter int CHECK_ADDR     = 12,
  parameter int CHECK_VALUE    = 7,
  parameter int TIMEOUT_CYCLES = 500000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_sel,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_last,
  output logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  input  logic                  im_rd,
  output logic [DATA_WIDTH-1:0] im_r_data,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  localparam int IM_AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;
  localparam int DM_AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] CHECK_WORD   = DATA_WIDTH'(CHECK_VALUE);
  localparam logic [ADDR_WIDTH-1:0] CHECK_A      = ADDR_WIDTH'(CHECK_ADDR);

  typedef enum logic [2:0] {LOAD, START, RUN, CHECK, DONE} state_t;

  state_t state_reg;

  logic [DATA_WIDTH-1:0] im_mem [IM_DEPTH];
  logic [DATA_WIDTH-1:0] dm_mem [DM_DEPTH];

  logic                  im_rd_ok, dm_ok, host_im_ok, host_dm_ok;
  logic                  im_we, dm_we;
  logic [ADDR_WIDTH-1:0] dm_waddr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] check_mem_word;
  logic [DATA_WIDTH-1:0] check_word_reg;

  // Range checks collapse to constants when the memory spans the full address space.
  generate
    if (IM_DEPTH < 2**ADDR_WIDTH) begin : g_im_range
      assign im_rd_ok   = im_addr   < ADDR_WIDTH'(IM_DEPTH);
      assign host_im_ok = host_addr < ADDR_WIDTH'(IM_DEPTH);
    end else begin : g_im_full
      assign im_rd_ok   = 1'b1;
      assign host_im_ok = 1'b1;
    end
    if (DM_DEPTH < 2**ADDR_WIDTH) begin : g_dm_range
      assign dm_ok      = dm_addr   < ADDR_WIDTH'(DM_DEPTH);
      assign host_dm_ok = host_addr < ADDR_WIDTH'(DM_DEPTH);
    end else begin : g_dm_full
      assign dm_ok      = 1'b1;
      assign host_dm_ok = 1'b1;
    end
    if (CHECK_ADDR < DM_DEPTH) begin : g_check_in
      assign check_mem_word = dm_mem[DM_AW'(CHECK_ADDR)];
    end else begin : g_check_out
      assign check_mem_word = '0;
    end
  endgenerate

  assign host_ready = (state_reg == LOAD);

  // One shared DM write port: host beats in LOAD, processor stores in RUN.
  always_comb begin
    im_we    = 1'b0;
    dm_we    = 1'b0;
    dm_waddr = dm_addr;
    dm_wdata = dm_w_data;
    if (!rst && state_reg == LOAD && host_valid) begin
      if (host_sel) begin
        dm_we    = host_dm_ok;
        dm_waddr = host_addr;
        dm_wdata = host_data;
      end else begin
        im_we = host_im_ok;
      end
    end else if (!rst && state_reg == RUN && dm_wr) begin
      dm_we = dm_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (im_we) im_mem[host_addr[IM_AW-1:0]] <= host_data;
  end

  always_ff @(posedge clk) begin
    if (dm_we) dm_mem[dm_waddr[DM_AW-1:0]] <= dm_wdata;
  end

  // Registered reads; non-blocking ordering gives read-before-write on a DM collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      im_r_data <= '0;
      dm_r_data <= '0;
    end else if (state_reg == RUN) begin
      if (im_rd) im_r_data <= im_rd_ok ? im_mem[im_addr[IM_AW-1:0]] : '0;
      if (dm_rd) dm_r_data <= dm_ok ? dm_mem[dm_addr[DM_AW-1:0]] : '0;
    end
  end

  // Snapshot the checked word on the stop edge, forwarding a store that lands on it that same cycle.
  always_ff @(posedge clk) begin
    if (state_reg == RUN && stop)
      check_word_reg <= (dm_we && dm_waddr == CHECK_A) ? dm_wdata : check_mem_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= LOAD;
      start       <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (host_valid && host_last) begin
            state_reg <= START;
            start     <= 1'b1;
          end
        end
        START: begin
          start     <= 1'b0;
          state_reg <= RUN;
        end
        RUN: begin
          if (stop) begin
            state_reg <= CHECK;
          end else if (cycle_count == TIMEOUT_LAST) begin
            state_reg <= DONE;
            timeout   <= 1'b1;
            pass      <= 1'b0;
            done      <= 1'b1;
          end else if (cycle_count != {CNT_WIDTH{1'b1}}) begin
            cycle_count <= cycle_count + 1'b1;
          end
        end
        CHECK: begin
          pass      <= (check_word_reg == CHECK_WORD);
          done      <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          state_reg <= DONE;
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Synthesizable memory-side responder for the 16-bit pipelined processor.
- Holds instruction memory (IM) and data memory (DM) and answers the processor's im_*/dm_* requests.
- Drives the processor start pulse and watches its stop output.
- A host port preloads both memories. After stop, the block checks one DM word against an expected value and reports pass/fail/timeout, so a run can be self-checked on FPGA or in a gate-level bench.

Parameters:
ADDR_WIDTH, 8, processor and host address width
DATA_WIDTH, 16, memory word width
IM_DEPTH, 256, IM words (at most 2**ADDR_WIDTH)
DM_DEPTH, 256, DM words (at most 2**ADDR_WIDTH)
CHECK_ADDR, 12, DM address inspected after stop
CHECK_VALUE, 7, expected DM[CHECK_ADDR]
TIMEOUT_CYCLES, 500000, RUN cycles allowed before timeout
CNT_WIDTH, 32, cycle_count width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
host_valid  in  1  host load beat valid
host_ready  out  1  block accepts host beats (LOAD state only)
host_sel  in  1  0 = IM, 1 = DM
host_addr  in  ADDR_WIDTH  load address
host_data  in  DATA_WIDTH  load data
host_last  in  1  final load beat; ends LOAD
start  out  1  one-cycle processor start pulse
stop  in  1  processor halted
im_addr  in  ADDR_WIDTH  instruction fetch address
im_rd  in  1  instruction read enable
im_r_data  out  DATA_WIDTH  instruction read data
dm_addr  in  ADDR_WIDTH  data address
dm_rd  in  1  data read enable
dm_wr  in  1  data write enable
dm_w_data  in  DATA_WIDTH  data write value
dm_r_data  out  DATA_WIDTH  data read data
done  out  1  run finished (check done or timeout)
pass  out  1  DM[CHECK_ADDR] == CHECK_VALUE
timeout  out  1  TIMEOUT_CYCLES elapsed without stop
cycle_count  out  CNT_WIDTH  RUN cycles counted

Behaviour:
- Reset values: state = LOAD, start 0, im_r_data 0, dm_r_data 0, done 0, pass 0, timeout 0, cycle_count 0.
- Reset does not clear IM/DM contents.
- Reset in any state, including mid-RUN, returns to LOAD on the next edge.
- FSM states: LOAD, START, RUN, CHECK, DONE.
- LOAD:
  - host_ready = 1.
  - On host_valid & host_ready, write host_data to IM[host_addr] or DM[host_addr] per host_sel.
  - If host_last is also set, perform the write and go to START.
  - Processor ports are ignored: no DM writes, read data registers hold.
- START:
  - start = 1 for exactly this one cycle; go to RUN.
  - stop is ignored in this state.
  - host_ready = 0 in every state except LOAD.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - If stop = 1, go to CHECK.
  - Else if cycle_count == TIMEOUT_CYCLES-1, go to DONE with timeout = 1, pass = 0, done = 1.
  - If stop and the timeout limit coincide, stop wins.
- Processor reads (RUN only):
  - One-cycle latency: at an edge with im_rd = 1, im_r_data <= IM[im_addr]; with im_rd = 0, im_r_data holds.
  - dm_rd / dm_r_data behave the same way against DM.
- Processor writes (RUN only): at an edge with dm_wr = 1, DM[dm_addr] <= dm_w_data.
- Same-address dm_rd and dm_wr in one cycle: read-before-write, so dm_r_data returns the old word.
- A write on the same cycle stop is sampled still commits.
- Out-of-range addresses (>= depth): writes dropped, reads return 0.
- CHECK:
  - Registers pass = (DM[CHECK_ADDR] == CHECK_VALUE), done = 1.
  - Go to DONE.
  - The check sees any write committed on the stop cycle.
- DONE: done, pass, timeout and cycle_count hold until rst; all ports are ignored.
- Latency: done rises 2 cycles after the cycle in which stop = 1 is sampled.
- Write widths are exactly DATA_WIDTH; no sign handling.

Test Plan:
1. Assert rst 3 cycles, release -> host_ready = 1, start = 0, done = 0, pass = 0, timeout = 0, cycle_count = 0, im_r_data = 0.
2. Load IM[0] = 16'h1234, DM[12] = 16'h0003 (last) -> host_ready drops next cycle; start = 1 for exactly one cycle; then RUN with cycle_count counting from 0.
3. RUN, im_rd = 1, im_addr = 0 -> im_r_data = 16'h1234 the next cycle. Then im_rd = 0, im_addr = 5 -> im_r_data stays 16'h1234.
4. RUN, same cycle dm_wr = 1 and dm_rd = 1 at addr 12 with dm_w_data = 7 -> dm_r_data = 3 the next cycle. Re-read -> 7. Then stop = 1 -> done = 1, pass = 1 two cycles later.
5. Rerun with DM[12] ending at 5 -> done = 1, pass = 0. Separately, TIMEOUT_CYCLES = 16 and no stop -> done = 1, timeout = 1, pass = 0, cycle_count = 15.
6. rst mid-RUN -> state LOAD, host_ready = 1, start = 0, done = 0. Memory is retained: DM write of 9 at addr 4 during the previous run reads back as 9 on the next run.
